// File: rtl/wide_adder_seq.sv
// rtl/wide_adder_seq.sv - sequential wide adder built from one 4-bit slice adder
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in by streaming them through a
//   single adder_4bit, one 4-bit slice per clock, least significant slice first.
//   Operands enter through a valid/ready handshake; the assembled sum and the
//   carry out of the top slice leave through a second valid/ready handshake.
//
// Ports (wide_adder_seq):
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active high
//   in_valid   in   1      a, b, carry_in valid
//   in_ready   out  1      operands accepted (high only in IDLE)
//   a, b       in   WIDTH  operands
//   carry_in   in   1      carry into slice 0
//   out_valid  out  1      sum/overflow valid (high only in DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  registered a+b+carry_in mod 2^WIDTH
//   overflow   out  1      registered carry out of the top slice
//
// Ports (adder_4bit):
//   i_a, i_b   in   4      slice operands
//   i_carry    in   1      slice carry in
//   o_sum      out  4      slice sum
//   o_carry    out  1      slice carry out

module adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_carry,
    output logic [3:0] o_sum,
    output logic       o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_carry};

endmodule

module wide_adder_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / 4;
    // A single-slice instance still needs a 1-bit index to keep widths legal.
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("wide_adder_seq: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_overflow;

    logic [3:0]       w_a_slice;
    logic [3:0]       w_b_slice;
    logic [3:0]       w_slice_sum;
    logic             w_slice_carry;

    // Select the operand slice addressed by the index. A compare-per-slice mux
    // keeps every part-select constant, so no out-of-range select can exist.
    always_comb begin
        w_a_slice = 4'h0;
        w_b_slice = 4'h0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_slice = r_a[i*4 +: 4];
                w_b_slice = r_b[i*4 +: 4];
            end
        end
    end

    adder_4bit u_adder (
        .i_a     (w_a_slice),
        .i_b     (w_b_slice),
        .i_carry (r_carry),
        .o_sum   (w_slice_sum),
        .o_carry (w_slice_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= carry_in;
                        r_idx   <= '0;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_sum[i*4 +: 4] <= w_slice_sum;
                        end
                    end
                    r_carry <= w_slice_carry;
                    if (r_idx == LAST_IDX) begin
                        r_overflow <= w_slice_carry;
                        r_idx      <= '0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result held until the consumer takes it; IDLE is entered
                    // first, so a waiting source is accepted one cycle later.
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign overflow  = r_overflow;

endmodule
